// File: rtl/timing_sequencer_pkg.sv
// Shared definitions for the POP timing sequencer.
//   - FSM encodings for the run controller (IDLE / RUN).
//   - Run-mode encodings sampled at the end of the last state.
//   - Default prescale for the 2.5 MHz system clock (100 us tick).
package timing_sequencer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  // 2.5 MHz / 250 = 10 kHz tick, i.e. 100 us per dwell unit.
  localparam int DEFAULT_PRESCALE = 250;

endpackage

// File: rtl/timing_sequencer_tick_prescaler.sv
// tick_prescaler: divides clk by PRESCALE (any value >= 2) and emits a
// one-clk tick on the last count of every period.
// Ports:
//   clk    in  system clock, posedge
//   reset  in  synchronous active-high reset, count -> 0
//   clear  in  synchronous count clear (restart the period)
//   en     in  count enable; the count and tick freeze while low
//   tick   out high for the clk where count == PRESCALE-1 and en=1
module tick_prescaler
  import timing_sequencer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] count;

  // Tick is gated by en so a frozen sequencer never sees a stale tick.
  assign tick = en && (count == CW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/timing_sequencer.sv
// timing_sequencer: steps through STATES states, holding each for a
// programmable number of prescaled ticks. Runs continuously (wrapping) or
// as a single pass, launched by start and frozen by enable.
// Ports:
//   clk           in  system clock, posedge
//   reset         in  synchronous active-high reset, overrides all inputs
//   enable        in  1 = advance, 0 = freeze a running sequence
//   mode          in  0 = continuous wrap, 1 = single pass then idle
//   start         in  one-clk pulse launching a run from IDLE
//   cfg_we        in  dwell table write strobe
//   cfg_addr      in  dwell table index (writes >= STATES are dropped)
//   cfg_data      in  dwell value in ticks (0 behaves as 1)
//   state         out current state index
//   state_strobe  out one-clk pulse on every state entry, including wrap
//   cycle_done    out one-clk pulse when the last state's dwell expires
//   busy          out high while the FSM is in RUN (FSM state visibility)
//   tick          out prescaler tick, for monitoring
module timing_sequencer
  import timing_sequencer_pkg::*;
#(
  parameter int STATES   = 7,
  parameter int SW       = 3,
  parameter int DW       = 16,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          mode,
  input  logic          start,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic [SW-1:0] state,
  output logic          state_strobe,
  output logic          cycle_done,
  output logic          busy,
  output logic          tick
);

  logic [DW-1:0] dwell_tbl [STATES];
  logic [0:0]    fsm_q;
  logic [DW-1:0] dwell_cnt;

  logic          run_start;
  logic          presc_en;
  logic          expire;
  logic          last_state;
  logic [SW-1:0] next_state;

  assign run_start  = (fsm_q == ST_IDLE) && start && enable;
  assign presc_en   = (fsm_q == ST_RUN) && enable;
  // A counter of 0 or 1 expires on the next tick, so a stored 0 acts as 1.
  assign expire     = tick && (dwell_cnt <= DW'(1));
  assign last_state = (state == SW'(STATES - 1));
  assign next_state = state + SW'(1);

  // Clearing on run entry aligns tick phase with the first dwell period.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (run_start),
    .en    (presc_en),
    .tick  (tick)
  );

  // Dwell table. Reads elsewhere see the pre-write value on the write edge,
  // so a write to the state being entered only affects its next entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STATES; i++) begin
        dwell_tbl[i] <= DW'(1);
      end
    end else if (cfg_we && (int'(cfg_addr) < STATES)) begin
      dwell_tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= ST_IDLE;
      state        <= '0;
      state_strobe <= 1'b0;
      cycle_done   <= 1'b0;
      busy         <= 1'b0;
      dwell_cnt    <= '0;
    end else begin
      state_strobe <= 1'b0;
      cycle_done   <= 1'b0;
      if (fsm_q == ST_IDLE) begin
        if (run_start) begin
          fsm_q        <= ST_RUN;
          state        <= '0;
          busy         <= 1'b1;
          state_strobe <= 1'b1;
          dwell_cnt    <= dwell_tbl[0];
        end
      end else if (expire) begin
        if (!last_state) begin
          state        <= next_state;
          state_strobe <= 1'b1;
          dwell_cnt    <= dwell_tbl[next_state];
        end else if (mode == MODE_SINGLE) begin
          fsm_q      <= ST_IDLE;
          state      <= '0;
          busy       <= 1'b0;
          cycle_done <= 1'b1;
        end else begin
          state        <= '0;
          state_strobe <= 1'b1;
          cycle_done   <= 1'b1;
          dwell_cnt    <= dwell_tbl[0];
        end
      end else if (tick) begin
        dwell_cnt <= dwell_cnt - DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Testbench for timing_sequencer (STATES=3, SW=2, DW=8, PRESCALE=4).
// A reference model tracks each state as a budget of enabled clocks
// (max(dwell,1)*PRESCALE) and pushes the expected state-entry / cycle-end
// events; a monitor pops them whenever the DUT pulses state_strobe or
// cycle_done and compares cycle, state and flags.
module tb_timing_sequencer;

  localparam int STATES   = 3;
  localparam int SW       = 2;
  localparam int DW       = 8;
  localparam int PRESCALE = 4;
  localparam int EW       = 32 + SW + 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic          start = 1'b0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [SW-1:0] state;
  logic          state_strobe;
  logic          cycle_done;
  logic          busy;
  logic          tick;

  always #5 clk = ~clk;

  timing_sequencer #(
    .STATES   (STATES),
    .SW       (SW),
    .DW       (DW),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .start        (start),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .state        (state),
    .state_strobe (state_strobe),
    .cycle_done   (cycle_done),
    .busy         (busy),
    .tick         (tick)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_ticks = 0;
  int dut_ticks = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [EW-1:0] ev(input int c, input int s, input bit stb,
                                        input bit done, input bit bsy);
    logic [31:0]   cv;
    logic [SW-1:0] sv;
    cv = c;
    sv = s[SW-1:0];
    return {cv, sv, stb, done, bsy};
  endfunction

  // ---------------- reference model ----------------
  bit m_run   = 0;
  int m_state = 0;
  int m_left  = 0;  // enabled clocks left in the current state
  int m_tbl[STATES] = '{default: 1};

  function automatic int eff(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  always @(posedge clk) begin
    cyc++;
    // A tick is visible on the last enabled clock of every PRESCALE period.
    if (m_run && enable && (m_left % PRESCALE == 1)) exp_ticks++;
    if (reset) begin
      m_run   = 0;
      m_state = 0;
      m_left  = 0;
      foreach (m_tbl[i]) m_tbl[i] = 1;
    end else begin
      if (!m_run) begin
        if (start && enable) begin
          m_run   = 1;
          m_state = 0;
          m_left  = eff(m_tbl[0]) * PRESCALE;
          exp_q.push_back(ev(cyc, 0, 1, 0, 1));
        end
      end else if (enable) begin
        m_left--;
        if (m_left == 0) begin
          if (m_state < STATES - 1) begin
            m_state++;
            m_left = eff(m_tbl[m_state]) * PRESCALE;
            exp_q.push_back(ev(cyc, m_state, 1, 0, 1));
          end else if (mode == 1'b0) begin
            m_state = 0;
            m_left  = eff(m_tbl[0]) * PRESCALE;
            exp_q.push_back(ev(cyc, 0, 1, 1, 1));
          end else begin
            m_run   = 0;
            m_state = 0;
            exp_q.push_back(ev(cyc, 0, 0, 1, 0));
          end
        end
      end
      // Table update after the reads above: a same-edge write is seen next entry.
      if (cfg_we && (int'(cfg_addr) < STATES)) m_tbl[cfg_addr] = int'(cfg_data);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (tick) dut_ticks++;
    if (state_strobe || cycle_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_event: got state=%0d strobe=%0b done=%0b busy=%0b, expected no event (cycle %0d)",
                 state, state_strobe, cycle_done, busy, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
        check("event_state", 64'(state), 64'(e[SW+2:3]));
        check("event_flags", 64'({state_strobe, cycle_done, busy}), 64'(e[2:0]));
      end
    end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_event: got no strobe/done, expected state=%0d flags=%0b (cycle %0d)",
               e[SW+2:3], e[2:0], cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    start  = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
  endtask

  task automatic write_cfg(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = a[SW-1:0];
    cfg_data = d[DW-1:0];
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({state, state_strobe, cycle_done, busy, tick}), 64'd0);

    // Default table, continuous: plain counter with a mid-run freeze.
    enable = 1'b1;
    mode   = 1'b0;
    pulse_start();
    repeat (17) step();
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    repeat (20) step();
    pulse_start();             // ignored while running
    write_cfg(3, 7);           // out of range, dropped
    write_cfg(1, 5);
    repeat (40) step();
    do_reset();                // table back to all 1s

    // Table {2,0,3}, single shot, then a start with enable low.
    write_cfg(0, 2);
    write_cfg(1, 0);
    write_cfg(2, 3);
    mode = 1'b1;
    pulse_start();
    repeat (40) step();
    enable = 1'b0;
    pulse_start();
    repeat (10) step();

    // Randomised runs: enable drops, mode toggles, table writes, stray starts.
    for (int ph = 0; ph < 12; ph++) begin
      mode   = 1'($urandom_range(0, 1));
      enable = 1'b1;
      pulse_start();
      for (int i = 0; i < 80; i++) begin
        enable = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) mode = ~mode;
        if ($urandom_range(0, 14) == 0) begin
          cfg_we   = 1'b1;
          cfg_addr = SW'($urandom_range(0, 3));
          cfg_data = DW'($urandom_range(0, 4));
        end
        if ($urandom_range(0, 19) == 0) start = 1'b1;
        step();
      end
      if ($urandom_range(0, 1) == 1) do_reset();
    end

    reset = 1'b1;
    repeat (2) step();
    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("tick_total", 64'(dut_ticks), 64'(exp_ticks));
    check("reset_idle", 64'({state, busy, tick}), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
